// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin front end for a single-port memory with an
// optional post-reset zero-fill sweep and registered read responses.
module mem_port_arbiter #(
    parameter int N              = 10,
    parameter int M              = 8,
    parameter bit CLEAR_ON_RESET = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         r0_valid,
    input  logic         r0_we,
    input  logic [N-1:0] r0_addr,
    input  logic [M-1:0] r0_wdata,
    output logic         r0_ready,
    output logic         r0_rvalid,
    output logic [M-1:0] r0_rdata,
    input  logic         r1_valid,
    input  logic         r1_we,
    input  logic [N-1:0] r1_addr,
    input  logic [M-1:0] r1_wdata,
    output logic         r1_ready,
    output logic         r1_rvalid,
    output logic [M-1:0] r1_rdata,
    output logic         mem_we,
    output logic [N-1:0] mem_a,
    output logic [M-1:0] mem_wd,
    input  logic [M-1:0] mem_rd,
    output logic         busy
);

    typedef enum logic {S_CLEAR, S_ARB} state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   clr_cnt;
    logic           last_grant;
    logic           grant0, grant1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if (CLEAR_ON_RESET) state <= S_CLEAR;
            else                state <= S_ARB;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_CLEAR) clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        grant0    = 1'b0;
        grant1    = 1'b0;
        mem_we    = 1'b0;
        mem_a     = '0;
        mem_wd    = '0;
        busy      = 1'b0;
        case (state)
            S_CLEAR: begin
                busy   = 1'b1;
                mem_we = 1'b1;
                mem_a  = clr_cnt;
                // Terminal compare: leave on the last address, never wrap.
                if (clr_cnt == {N{1'b1}}) state_nxt = S_ARB;
            end
            S_ARB: begin
                grant0 = r0_valid && (!r1_valid || last_grant);
                grant1 = r1_valid && (!r0_valid || !last_grant);
                if (grant0) begin
                    mem_we = r0_we;
                    mem_a  = r0_addr;
                    mem_wd = r0_wdata;
                end else if (grant1) begin
                    mem_we = r1_we;
                    mem_a  = r1_addr;
                    mem_wd = r1_wdata;
                end
            end
            default: state_nxt = S_ARB;
        endcase
    end

    assign r0_ready = grant0;
    assign r1_ready = grant1;

    // NOTE: read data registers are reset as well, because rdata must read
    // zero after reset rather than whatever the last response left behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r0_rvalid  <= 1'b0;
            r1_rvalid  <= 1'b0;
            r0_rdata   <= '0;
            r1_rdata   <= '0;
            last_grant <= 1'b1;
        end else begin
            r0_rvalid <= grant0 && !r0_we;
            r1_rvalid <= grant1 && !r1_we;
            if (grant0 && !r0_we) r0_rdata <= mem_rd;
            if (grant1 && !r1_we) r1_rdata <= mem_rd;
            if (grant0)      last_grant <= 1'b0;
            else if (grant1) last_grant <= 1'b1;
        end
    end

endmodule
